// File: rtl/reorder_buffer_pkg.sv
// Shared sizing, entry layout and helpers for the reorder buffer.
package reorder_buffer_pkg;

  localparam int ROB_SIZE       = 16;
  localparam int ROB_INDEX_SIZE = $clog2(ROB_SIZE);
  localparam int ROB_COUNT_SIZE = ROB_INDEX_SIZE + 1;
  localparam int RENAME_WIDTH   = 2;
  localparam int COMMIT_WIDTH   = 2;
  localparam int WB_WIDTH       = 2;
  localparam int PRF_INDEX_SIZE = 6;

  // One in-flight micro-op awaiting in-order retirement.
  typedef struct packed {
    logic                      valid;
    logic                      complete;
    logic                      mispredict;
    logic                      has_dst;
    logic [PRF_INDEX_SIZE-1:0] dst_prf;
    logic [PRF_INDEX_SIZE-1:0] pre_prf;
  } rob_entry_t;

  // Number of requesting rename lanes, sized to add directly onto the occupancy count.
  function automatic logic [ROB_COUNT_SIZE-1:0] count_ones(input logic [RENAME_WIDTH-1:0] v);
    logic [ROB_COUNT_SIZE-1:0] total;
    total = '0;
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      if (v[i]) begin
        total = total + ROB_COUNT_SIZE'(1);
      end
    end
    return total;
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: rename allocates at the tail, writeback marks
// entries complete, the head retires completed entries and returns physical
// registers to the free list. A retired mispredicted branch flushes everything.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    stall,
  input  logic [RENAME_WIDTH-1:0]                 alloc_valid,
  input  logic [RENAME_WIDTH-1:0]                 alloc_has_dst,
  input  logic [RENAME_WIDTH*PRF_INDEX_SIZE-1:0]  alloc_dst_prf,
  input  logic [RENAME_WIDTH*PRF_INDEX_SIZE-1:0]  alloc_pre_prf,
  output logic                                    alloc_ready,
  output logic [RENAME_WIDTH*ROB_INDEX_SIZE-1:0]  alloc_rob_idx,
  input  logic [WB_WIDTH-1:0]                     wb_valid,
  input  logic [WB_WIDTH*ROB_INDEX_SIZE-1:0]      wb_rob_idx,
  input  logic [WB_WIDTH-1:0]                     wb_mispredict,
  output logic [COMMIT_WIDTH-1:0]                 pre_prf_valid,
  output logic [COMMIT_WIDTH*PRF_INDEX_SIZE-1:0]  pre_prf,
  output logic [COMMIT_WIDTH-1:0]                 retire_prf_valid,
  output logic [COMMIT_WIDTH*PRF_INDEX_SIZE-1:0]  retire_prf,
  output logic                                    recover,
  output logic                                    empty
);

  localparam int IDX = ROB_INDEX_SIZE;
  localparam int CNT = ROB_COUNT_SIZE;
  localparam int PRF = PRF_INDEX_SIZE;

  // Entries are held in flops: commit reads several consecutive entries and
  // writeback/allocation update several arbitrary entries in the same cycle.
  rob_entry_t           entries_reg [ROB_SIZE];
  logic [IDX-1:0]       head_reg;
  logic [IDX-1:0]       tail_reg;
  logic [CNT-1:0]       count_reg;
  logic [CNT-1:0]       count_next;

  logic [CNT-1:0]       alloc_count;
  logic [CNT-1:0]       commit_count;
  logic                 alloc_accept;
  logic [IDX-1:0]       lane_idx [RENAME_WIDTH];
  logic [COMMIT_WIDTH-1:0] commit_lane;
  rob_entry_t           head_entry [COMMIT_WIDTH];

  assign alloc_count  = count_ones(alloc_valid);
  // Space check uses the current occupancy only; same-cycle retirements are not credited.
  assign alloc_ready  = ((CNT'(ROB_SIZE) - count_reg) >= alloc_count) && !recover;
  assign alloc_accept = alloc_ready && !stall;
  assign empty        = (count_reg == '0);

  // Pack requesting lanes onto consecutive tail slots in lane order; idle lanes report 0.
  always_comb begin
    logic [IDX-1:0] offset;
    offset = '0;
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      lane_idx[i] = '0;
      if (alloc_valid[i]) begin
        lane_idx[i] = tail_reg + offset;
        offset      = offset + IDX'(1);
      end
    end
  end

  // Retire a contiguous run of completed entries from the head, stopping after a mispredict.
  always_comb begin
    logic chain;
    chain        = 1'b1;
    recover      = 1'b0;
    commit_count = '0;
    commit_lane  = '0;
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      if (chain && !stall && head_entry[j].valid && head_entry[j].complete) begin
        commit_lane[j] = 1'b1;
        commit_count   = commit_count + CNT'(1);
        if (head_entry[j].mispredict) begin
          recover = 1'b1;
        end
        chain = !head_entry[j].mispredict;
      end else begin
        chain = 1'b0;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < RENAME_WIDTH; gi++) begin : g_alloc_lane
      assign alloc_rob_idx[gi*IDX +: IDX] = lane_idx[gi];
    end
    for (genvar gi = 0; gi < COMMIT_WIDTH; gi++) begin : g_commit_lane
      assign head_entry[gi]                = entries_reg[head_reg + IDX'(gi)];
      assign pre_prf_valid[gi]             = commit_lane[gi] && head_entry[gi].has_dst;
      assign retire_prf_valid[gi]          = commit_lane[gi] && head_entry[gi].has_dst;
      assign pre_prf[gi*PRF +: PRF]        = head_entry[gi].pre_prf;
      assign retire_prf[gi*PRF +: PRF]     = head_entry[gi].dst_prf;
    end
  endgenerate

  assign count_next = count_reg + (alloc_accept ? alloc_count : CNT'(0)) - commit_count;

  // Pointer and occupancy update; a recover collapses the buffer to empty.
  always_ff @(posedge clock) begin
    if (!reset || recover) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_reg + commit_count[IDX-1:0];
      if (alloc_accept) begin
        tail_reg <= tail_reg + alloc_count[IDX-1:0];
      end
      count_reg <= count_next;
    end
  end

  // Entry state: writeback completes live entries, commit frees head entries, rename fills tail slots.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int e = 0; e < ROB_SIZE; e++) begin
        entries_reg[e] <= '0;
      end
    end else if (recover) begin
      for (int e = 0; e < ROB_SIZE; e++) begin
        entries_reg[e].valid    <= 1'b0;
        entries_reg[e].complete <= 1'b0;
      end
    end else begin
      for (int k = 0; k < WB_WIDTH; k++) begin
        if (wb_valid[k] && entries_reg[wb_rob_idx[k*IDX +: IDX]].valid) begin
          entries_reg[wb_rob_idx[k*IDX +: IDX]].complete <= 1'b1;
          if (wb_mispredict[k]) begin
            entries_reg[wb_rob_idx[k*IDX +: IDX]].mispredict <= 1'b1;
          end
        end
      end
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
        if (commit_lane[j]) begin
          entries_reg[head_reg + IDX'(j)].valid <= 1'b0;
        end
      end
      // Allocation targets only free slots, so it never collides with the updates above.
      for (int i = 0; i < RENAME_WIDTH; i++) begin
        if (alloc_accept && alloc_valid[i]) begin
          entries_reg[lane_idx[i]] <= '{
            valid:      1'b1,
            complete:   1'b0,
            mispredict: 1'b0,
            has_dst:    alloc_has_dst[i],
            dst_prf:    alloc_dst_prf[i*PRF +: PRF],
            pre_prf:    alloc_pre_prf[i*PRF +: PRF]
          };
        end
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus randomized
// traffic compared against a queue-based model of in-order retirement.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  alloc_valid;
  logic [1:0]  alloc_has_dst;
  logic [11:0] alloc_dst_prf;
  logic [11:0] alloc_pre_prf;
  logic        alloc_ready;
  logic [7:0]  alloc_rob_idx;
  logic [1:0]  wb_valid;
  logic [7:0]  wb_rob_idx;
  logic [1:0]  wb_mispredict;
  logic [1:0]  pre_prf_valid;
  logic [11:0] pre_prf;
  logic [1:0]  retire_prf_valid;
  logic [11:0] retire_prf;
  logic        recover;
  logic        empty;

  int checks = 0;
  int failures = 0;

  reorder_buffer dut (
    .clock(clock), .reset(reset), .stall(stall),
    .alloc_valid(alloc_valid), .alloc_has_dst(alloc_has_dst),
    .alloc_dst_prf(alloc_dst_prf), .alloc_pre_prf(alloc_pre_prf),
    .alloc_ready(alloc_ready), .alloc_rob_idx(alloc_rob_idx),
    .wb_valid(wb_valid), .wb_rob_idx(wb_rob_idx), .wb_mispredict(wb_mispredict),
    .pre_prf_valid(pre_prf_valid), .pre_prf(pre_prf),
    .retire_prf_valid(retire_prf_valid), .retire_prf(retire_prf),
    .recover(recover), .empty(empty)
  );

  always #5 clock = ~clock;

  // Reference model: queue of in-flight ops in program order, oldest first.
  typedef struct {
    bit       has_dst;
    bit [5:0] dst;
    bit [5:0] pre;
    bit       complete;
    bit       mis;
  } m_entry_t;

  m_entry_t m_q[$];
  int       m_head = 0;

  bit        exp_ready;
  bit [7:0]  exp_idx;
  bit [1:0]  exp_pv;
  bit [11:0] exp_pre;
  bit [11:0] exp_ret;
  bit        exp_recover;
  bit        exp_empty;
  int        exp_commits;

  function automatic void model_eval();
    int  n;
    int  k;
    bit  stop;
    n = 0;
    for (int i = 0; i < 2; i++) if (alloc_valid[i]) n++;
    exp_recover = 0;
    exp_commits = 0;
    exp_pv = '0;
    exp_pre = '0;
    exp_ret = '0;
    stop = 0;
    for (int j = 0; j < 2; j++) begin
      if (!stop && !stall && j < m_q.size() && m_q[j].complete) begin
        exp_commits++;
        exp_pv[j] = m_q[j].has_dst;
        if (m_q[j].has_dst) begin
          exp_pre[j*6 +: 6] = m_q[j].pre;
          exp_ret[j*6 +: 6] = m_q[j].dst;
        end
        if (m_q[j].mis) begin
          exp_recover = 1;
          stop = 1;
        end
      end else begin
        stop = 1;
      end
    end
    exp_ready = (16 - m_q.size() >= n) && !exp_recover;
    k = 0;
    exp_idx = '0;
    for (int i = 0; i < 2; i++) begin
      if (alloc_valid[i]) begin
        exp_idx[i*4 +: 4] = 4'((m_head + m_q.size() + k) % 16);
        k++;
      end
    end
    exp_empty = (m_q.size() == 0);
  endfunction

  function automatic void model_advance();
    m_entry_t e;
    int p;
    if (!reset) begin
      m_q.delete();
      m_head = 0;
      return;
    end
    if (!exp_recover) begin
      for (int k = 0; k < 2; k++) begin
        if (wb_valid[k]) begin
          p = (int'(wb_rob_idx[k*4 +: 4]) - m_head + 16) % 16;
          if (p < m_q.size()) begin
            m_q[p].complete = 1;
            if (wb_mispredict[k]) m_q[p].mis = 1;
          end
        end
      end
    end
    if (exp_recover) begin
      m_q.delete();
      m_head = 0;
      return;
    end
    for (int j = 0; j < exp_commits; j++) void'(m_q.pop_front());
    m_head = (m_head + exp_commits) % 16;
    if (exp_ready && !stall) begin
      for (int i = 0; i < 2; i++) begin
        if (alloc_valid[i]) begin
          e.has_dst  = alloc_has_dst[i];
          e.dst      = alloc_dst_prf[i*6 +: 6];
          e.pre      = alloc_pre_prf[i*6 +: 6];
          e.complete = 0;
          e.mis      = 0;
          m_q.push_back(e);
        end
      end
    end
  endfunction

  task automatic idle_inputs();
    stall = 0;
    alloc_valid = '0;
    alloc_has_dst = '0;
    alloc_dst_prf = '0;
    alloc_pre_prf = '0;
    wb_valid = '0;
    wb_rob_idx = '0;
    wb_mispredict = '0;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic next_cycle();
    model_eval();
    @(posedge clock);
    model_advance();
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic reset_dut();
    reset = 0;
    next_cycle();
    next_cycle();
    reset = 1;
  endtask

  task automatic test_reset();
    reset = 0;
    idle_inputs();
    next_cycle();
    next_cycle();
    reset = 1;
    settle();
    checks++;
    if (alloc_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", alloc_ready); end
    checks++;
    if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b want=1", empty); end
    checks++;
    if (pre_prf_valid !== 2'b00 || retire_prf_valid !== 2'b00 || recover !== 1'b0) begin
      failures++;
      $display("FAIL reset_commit got pv=%b rv=%b rec=%b want 00 00 0", pre_prf_valid, retire_prf_valid, recover);
    end
  endtask

  task automatic test_basic();
    reset_dut();
    alloc_valid = 2'b11; alloc_has_dst = 2'b11;
    alloc_dst_prf = {6'd34, 6'd33}; alloc_pre_prf = {6'd2, 6'd1};
    settle();
    checks++;
    if (alloc_rob_idx !== 8'h10) begin failures++; $display("FAIL basic_alloc_idx got=%h want=10", alloc_rob_idx); end
    next_cycle();
    settle();
    checks++;
    if (empty !== 1'b0 || pre_prf_valid !== 2'b00) begin
      failures++; $display("FAIL basic_after_alloc got empty=%b pv=%b want 0 00", empty, pre_prf_valid);
    end
    wb_valid = 2'b01; wb_rob_idx = 8'h01;
    settle();
    checks++;
    if (pre_prf_valid !== 2'b00) begin failures++; $display("FAIL basic_wb1 got pv=%b want 00", pre_prf_valid); end
    next_cycle();
    wb_valid = 2'b01; wb_rob_idx = 8'h00;
    settle();
    checks++;
    if (retire_prf_valid !== 2'b00) begin failures++; $display("FAIL basic_order got rv=%b want 00", retire_prf_valid); end
    next_cycle();
    settle();
    checks++;
    if (pre_prf_valid !== 2'b11 || retire_prf_valid !== 2'b11 || pre_prf !== {6'd2, 6'd1} || retire_prf !== {6'd34, 6'd33}) begin
      failures++;
      $display("FAIL basic_commit got pv=%b rv=%b pre=%h ret=%h want 11 11 %h %h",
               pre_prf_valid, retire_prf_valid, pre_prf, retire_prf, {6'd2, 6'd1}, {6'd34, 6'd33});
    end
    next_cycle();
    settle();
    checks++;
    if (empty !== 1'b1) begin failures++; $display("FAIL basic_drained got empty=%b want 1", empty); end
  endtask

  task automatic test_full();
    reset_dut();
    for (int c = 0; c < 8; c++) begin
      alloc_valid = 2'b11; alloc_has_dst = 2'b11;
      alloc_dst_prf = 12'($urandom); alloc_pre_prf = 12'($urandom);
      settle();
      checks++;
      if (alloc_ready !== 1'b1) begin failures++; $display("FAIL full_fill%0d got ready=%b want 1", c, alloc_ready); end
      next_cycle();
    end
    alloc_valid = 2'b01;
    wb_valid = 2'b11; wb_rob_idx = 8'h10;
    settle();
    checks++;
    if (alloc_ready !== 1'b0) begin failures++; $display("FAIL full_blocked got ready=%b want 0", alloc_ready); end
    next_cycle();
    alloc_valid = 2'b01;
    settle();
    checks++;
    if (alloc_ready !== 1'b0 || retire_prf_valid !== 2'b11) begin
      failures++; $display("FAIL full_commit got ready=%b rv=%b want 0 11", alloc_ready, retire_prf_valid);
    end
    next_cycle();
    alloc_valid = 2'b11;
    settle();
    checks++;
    if (alloc_ready !== 1'b1 || alloc_rob_idx !== 8'h10) begin
      failures++; $display("FAIL full_wrap got ready=%b idx=%h want 1 10", alloc_ready, alloc_rob_idx);
    end
    next_cycle();
  endtask

  task automatic test_sparse();
    reset_dut();
    alloc_valid = 2'b01;
    next_cycle();
    alloc_valid = 2'b10;
    settle();
    checks++;
    if (alloc_rob_idx !== 8'h10) begin failures++; $display("FAIL sparse_lane1 got idx=%h want 10", alloc_rob_idx); end
    next_cycle();
    alloc_valid = 2'b11;
    settle();
    checks++;
    if (alloc_rob_idx !== 8'h32) begin failures++; $display("FAIL sparse_next got idx=%h want 32", alloc_rob_idx); end
    next_cycle();
  endtask

  task automatic test_recover();
    reset_dut();
    alloc_valid = 2'b11; alloc_has_dst = 2'b11;
    alloc_dst_prf = {6'd41, 6'd40}; alloc_pre_prf = {6'd5, 6'd4};
    next_cycle();
    wb_valid = 2'b11; wb_rob_idx = 8'h10; wb_mispredict = 2'b01;
    next_cycle();
    alloc_valid = 2'b11;
    settle();
    checks++;
    if (recover !== 1'b1 || retire_prf_valid !== 2'b01 || pre_prf_valid !== 2'b01 || retire_prf[5:0] !== 6'd40) begin
      failures++;
      $display("FAIL recover_pulse got rec=%b rv=%b pv=%b ret0=%0d want 1 01 01 40",
               recover, retire_prf_valid, pre_prf_valid, retire_prf[5:0]);
    end
    checks++;
    if (alloc_ready !== 1'b0) begin failures++; $display("FAIL recover_alloc got ready=%b want 0", alloc_ready); end
    next_cycle();
    alloc_valid = 2'b01;
    settle();
    checks++;
    if (recover !== 1'b0 || empty !== 1'b1 || alloc_ready !== 1'b1 || alloc_rob_idx !== 8'h00) begin
      failures++;
      $display("FAIL recover_after got rec=%b empty=%b ready=%b idx=%h want 0 1 1 00",
               recover, empty, alloc_ready, alloc_rob_idx);
    end
    next_cycle();
  endtask

  task automatic test_stall();
    reset_dut();
    alloc_valid = 2'b11; alloc_has_dst = 2'b01;
    alloc_dst_prf = {6'd51, 6'd50}; alloc_pre_prf = {6'd9, 6'd8};
    next_cycle();
    stall = 1; wb_valid = 2'b11; wb_rob_idx = 8'h10; alloc_valid = 2'b01;
    settle();
    checks++;
    if (pre_prf_valid !== 2'b00 || retire_prf_valid !== 2'b00) begin
      failures++; $display("FAIL stall_wb got pv=%b rv=%b want 00 00", pre_prf_valid, retire_prf_valid);
    end
    next_cycle();
    stall = 1;
    settle();
    checks++;
    if (pre_prf_valid !== 2'b00 || retire_prf_valid !== 2'b00 || recover !== 1'b0) begin
      failures++; $display("FAIL stall_hold got pv=%b rv=%b rec=%b want 00 00 0", pre_prf_valid, retire_prf_valid, recover);
    end
    next_cycle();
    alloc_valid = 2'b01;
    settle();
    checks++;
    if (pre_prf_valid !== 2'b01 || retire_prf_valid !== 2'b01 || retire_prf[5:0] !== 6'd50 || pre_prf[5:0] !== 6'd8) begin
      failures++;
      $display("FAIL stall_release got pv=%b rv=%b ret0=%0d pre0=%0d want 01 01 50 8",
               pre_prf_valid, retire_prf_valid, retire_prf[5:0], pre_prf[5:0]);
    end
    checks++;
    if (alloc_rob_idx !== 8'h02) begin failures++; $display("FAIL stall_tail got idx=%h want 02", alloc_rob_idx); end
    next_cycle();
  endtask

  task automatic test_random();
    bit [11:0] mask;
    reset_dut();
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
      stall = ($urandom_range(0, 7) == 0);
      alloc_valid = 2'($urandom);
      alloc_has_dst = 2'($urandom);
      alloc_dst_prf = 12'($urandom);
      alloc_pre_prf = 12'($urandom);
      for (int k = 0; k < 2; k++) begin
        wb_valid[k] = ($urandom_range(0, 2) != 0);
        if (m_q.size() > 0 && $urandom_range(0, 3) != 0)
          wb_rob_idx[k*4 +: 4] = 4'((m_head + $urandom_range(0, m_q.size() - 1)) % 16);
        else
          wb_rob_idx[k*4 +: 4] = 4'($urandom);
        wb_mispredict[k] = ($urandom_range(0, 11) == 0);
      end
      settle();
      if (reset) begin
        mask = {{6{exp_pv[1]}}, {6{exp_pv[0]}}};
        checks++;
        if (alloc_ready !== exp_ready || alloc_rob_idx !== exp_idx) begin
          failures++;
          $display("FAIL rand_alloc cyc=%0d got ready=%b idx=%h want %b %h", c, alloc_ready, alloc_rob_idx, exp_ready, exp_idx);
        end
        checks++;
        if (pre_prf_valid !== exp_pv || retire_prf_valid !== exp_pv || recover !== exp_recover) begin
          failures++;
          $display("FAIL rand_commit cyc=%0d got pv=%b rv=%b rec=%b want %b %b %b",
                   c, pre_prf_valid, retire_prf_valid, recover, exp_pv, exp_pv, exp_recover);
        end
        checks++;
        if ((pre_prf & mask) !== exp_pre || (retire_prf & mask) !== exp_ret) begin
          failures++;
          $display("FAIL rand_prf cyc=%0d got pre=%h ret=%h want %h %h", c, pre_prf & mask, retire_prf & mask, exp_pre, exp_ret);
        end
        checks++;
        if (empty !== exp_empty) begin
          failures++; $display("FAIL rand_empty cyc=%0d got=%b want=%b", c, empty, exp_empty);
        end
      end
      next_cycle();
      reset = 1;
    end
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    @(negedge clock);
    test_reset();
    test_basic();
    test_full();
    test_sparse();
    test_recover();
    test_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
